// File: rtl/acq_scheduler.sv
// rtl/acq_scheduler.sv - one-at-a-time mic/position/overlay acquisition sequencer
// Optional coordinate smoothing is built when ACQ_SMOOTH_EN is defined.
module acq_scheduler #(
  parameter int          CW       = 26,
  parameter int          X_MAX    = 480,
  parameter int          Y_MAX    = 272,
  parameter logic [23:0] TIMEOUT  = 24'd6_000_000,
  parameter logic [19:0] HOLD_CYC = 20'd600_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          mic_done,
  input  logic          mic_valid,
  output logic          mic_start,
  output logic          pos_ena,
  input  logic          pos_done,
  input  logic [CW-1:0] x_in,
  input  logic [CW-1:0] y_in,
  output logic          ovl_ena,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          busy,
  output logic          err_timeout,
  output logic [15:0]   upd_cnt,
  output logic [15:0]   rej_cnt
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_MIC, CALC, WAIT_POS, UPDATE, HOLD
  } state_t;

  localparam logic [CW-1:0] X_LAST    = CW'(X_MAX - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(Y_MAX - 1);
  localparam logic [23:0]   TMO_LAST  = TIMEOUT - 24'd1;
  localparam logic [23:0]   HOLD_LAST = {4'd0, HOLD_CYC} - 24'd1;
  localparam logic [23:0]   TIMER_MAX = 24'hFF_FFFF;

  state_t        state_q, state_d;
  logic [23:0]   timer_q, timer_d;
  logic          mic_start_q, mic_start_d;
  logic          pos_ena_q, pos_ena_d;
  logic          ovl_ena_q, ovl_ena_d;
  logic [CW-1:0] pix_x_q, pix_x_d;
  logic [CW-1:0] pix_y_q, pix_y_d;
  logic          busy_q, busy_d;
  logic          err_timeout_q, err_timeout_d;
  logic [15:0]   upd_cnt_q, upd_cnt_d;
  logic [15:0]   rej_cnt_q, rej_cnt_d;

  logic [CW-1:0] x_clamp, y_clamp;
  logic          ovl_now;
  logic [CW-1:0] pix_x_new, pix_y_new;
  logic          expired;

  // Signed clamp of a solver coordinate into [0, last]
  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v, input logic [CW-1:0] last);
    logic [CW-1:0] r;
    r = v;
    if (v[CW-1]) r = '0;
    else if ($signed(v) > $signed(last)) r = last;
    return r;
  endfunction

  assign x_clamp = clamp(x_in, X_LAST);
  assign y_clamp = clamp(y_in, Y_LAST);
  assign expired = (timer_q == TMO_LAST);

  // Next-state logic; completion pulses take priority over timer expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (ena) state_d = START;
      START:    state_d = WAIT_MIC;
      WAIT_MIC: begin
        if (mic_done)     state_d = mic_valid ? CALC : HOLD;
        else if (expired) state_d = HOLD;
      end
      CALC:     state_d = WAIT_POS;
      WAIT_POS: begin
        if (pos_done)     state_d = UPDATE;
        else if (expired) state_d = HOLD;
      end
      UPDATE:   state_d = HOLD;
      HOLD:     if (timer_q == HOLD_LAST) state_d = ena ? START : IDLE;
      default:  state_d = IDLE;
    endcase
  end

`ifdef ACQ_SMOOTH_EN
  logic [CW-1:0] hx_q [4];
  logic [CW-1:0] hx_d [4];
  logic [CW-1:0] hy_q [4];
  logic [CW-1:0] hy_d [4];
  logic          hfull_q, hfull_d;
  logic [CW+1:0] sum_x, sum_y;

  // History push on UPDATE entry; the first sample primes all four slots
  always_comb begin
    hx_d    = hx_q;
    hy_d    = hy_q;
    hfull_d = hfull_q;
    if (state_d == UPDATE) begin
      if (!hfull_q) begin
        for (int i = 0; i < 4; i++) begin
          hx_d[i] = x_clamp;
          hy_d[i] = y_clamp;
        end
        hfull_d = 1'b1;
      end else begin
        for (int i = 3; i > 0; i--) begin
          hx_d[i] = hx_q[i-1];
          hy_d[i] = hy_q[i-1];
        end
        hx_d[0] = x_clamp;
        hy_d[0] = y_clamp;
      end
    end
    sum_x = ({2'b00, hx_q[0]} + {2'b00, hx_q[1]}) + ({2'b00, hx_q[2]} + {2'b00, hx_q[3]});
    sum_y = ({2'b00, hy_q[0]} + {2'b00, hy_q[1]}) + ({2'b00, hy_q[2]} + {2'b00, hy_q[3]});
  end

  // History storage, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hx_q[i] <= '0;
        hy_q[i] <= '0;
      end
      hfull_q <= 1'b0;
    end else begin
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      hfull_q <= hfull_d;
    end
  end

  assign ovl_now   = (state_q == UPDATE);
  assign pix_x_new = sum_x[CW+1:2];
  assign pix_y_new = sum_y[CW+1:2];
`else
  assign ovl_now   = (state_d == UPDATE);
  assign pix_x_new = x_clamp;
  assign pix_y_new = y_clamp;
`endif

  // Registered outputs are decoded from the next state so pulses line up with their state
  always_comb begin
    timer_d       = (state_d != state_q) ? 24'd0 :
                    (timer_q == TIMER_MAX) ? timer_q : timer_q + 24'd1;
    mic_start_d   = (state_d == START);
    pos_ena_d     = (state_d == CALC);
    busy_d        = (state_d != IDLE);
    ovl_ena_d     = ovl_now;
    pix_x_d       = ovl_now ? pix_x_new : pix_x_q;
    pix_y_d       = ovl_now ? pix_y_new : pix_y_q;
    upd_cnt_d     = upd_cnt_q + ((state_d == UPDATE) ? 16'd1 : 16'd0);
    rej_cnt_d     = rej_cnt_q;
    err_timeout_d = err_timeout_q;
    if (state_q == WAIT_MIC && mic_done && !mic_valid) rej_cnt_d = rej_cnt_q + 16'd1;
    if (expired && ((state_q == WAIT_MIC && !mic_done) || (state_q == WAIT_POS && !pos_done)))
      err_timeout_d = 1'b1;
    if (state_d == UPDATE) err_timeout_d = 1'b0;
  end

  // State, timer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      mic_start_q   <= 1'b0;
      pos_ena_q     <= 1'b0;
      ovl_ena_q     <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      upd_cnt_q     <= '0;
      rej_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      mic_start_q   <= mic_start_d;
      pos_ena_q     <= pos_ena_d;
      ovl_ena_q     <= ovl_ena_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      upd_cnt_q     <= upd_cnt_d;
      rej_cnt_q     <= rej_cnt_d;
    end
  end

  assign mic_start   = mic_start_q;
  assign pos_ena     = pos_ena_q;
  assign ovl_ena     = ovl_ena_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign upd_cnt     = upd_cnt_q;
  assign rej_cnt     = rej_cnt_q;

endmodule

// File: tb/tb_acq_scheduler.sv
// tb/tb_acq_scheduler.sv - self-checking bench for acq_scheduler (honours ACQ_SMOOTH_EN)
module tb_acq_scheduler;
    localparam int CW  = 26;
    localparam int TMO = 100;
    localparam int HC  = 16;
`ifdef ACQ_SMOOTH_EN
    localparam bit OVL_EARLY = 1'b0;
    int seq_exp [4] = '{100, 125, 175, 250};
`else
    localparam bit OVL_EARLY = 1'b1;
    int seq_exp [4] = '{100, 200, 300, 400};
`endif

    logic          clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic          mic_done = 1'b0, mic_valid = 1'b0, pos_done = 1'b0;
    logic [CW-1:0] x_in = '0, y_in = '0;
    logic          mic_start, pos_ena, ovl_ena, busy, err_timeout;
    logic [CW-1:0] pix_x, pix_y;
    logic [15:0]   upd_cnt, rej_cnt;

    acq_scheduler #(.CW(CW), .X_MAX(480), .Y_MAX(272), .TIMEOUT(24'd100), .HOLD_CYC(20'd16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mic_done(mic_done), .mic_valid(mic_valid),
        .mic_start(mic_start), .pos_ena(pos_ena), .pos_done(pos_done), .x_in(x_in), .y_in(y_in),
        .ovl_ena(ovl_ena), .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .err_timeout(err_timeout),
        .upd_cnt(upd_cnt), .rej_cnt(rej_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0, hold_at = -1;
    int n_start = 0, n_pos = 0, n_ovl = 0;
    int exp_start = 0, exp_pos = 0, exp_ovl = 0, exp_upd = 0, exp_rej = 0;
    bit err_exp = 1'b0;
    int pix_x_exp = 0, pix_y_exp = 0;
    int hxq[$], hyq[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int clamp_m(input int v, input int lim);
        return (v < 0) ? 0 : ((v >= lim) ? lim - 1 : v);
    endfunction

    task automatic fail(input string tag, input int obs, input int exp);
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        if (mic_start === 1'b1) n_start++;
        if (pos_ena === 1'b1) n_pos++;
        if (ovl_ena === 1'b1) n_ovl++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic model_update(input int xv, input int yv);
        int cx, cy;
        cx = clamp_m(xv, 480);
        cy = clamp_m(yv, 272);
`ifdef ACQ_SMOOTH_EN
        if (hxq.size() == 0) begin
            repeat (4) begin hxq.push_front(cx); hyq.push_front(cy); end
        end else begin
            hxq.push_front(cx); void'(hxq.pop_back());
            hyq.push_front(cy); void'(hyq.pop_back());
        end
        pix_x_exp = (hxq[0] + hxq[1] + hxq[2] + hxq[3]) / 4;
        pix_y_exp = (hyq[0] + hyq[1] + hyq[2] + hyq[3]) / 4;
`else
        pix_x_exp = cx;
        pix_y_exp = cy;
`endif
    endtask

    task automatic chk_all_zero(input string w);
        vectors++; if (busy !== 1'b0) fail({w, " busy"}, busy, 0);
        vectors++; if (mic_start !== 1'b0) fail({w, " mic_start"}, mic_start, 0);
        vectors++; if (pos_ena !== 1'b0) fail({w, " pos_ena"}, pos_ena, 0);
        vectors++; if (ovl_ena !== 1'b0) fail({w, " ovl_ena"}, ovl_ena, 0);
        vectors++; if (pix_x !== '0) fail({w, " pix_x"}, pix_x, 0);
        vectors++; if (pix_y !== '0) fail({w, " pix_y"}, pix_y, 0);
        vectors++; if (err_timeout !== 1'b0) fail({w, " err_timeout"}, err_timeout, 0);
        vectors++; if (upd_cnt !== 16'd0) fail({w, " upd_cnt"}, upd_cnt, 0);
        vectors++; if (rej_cnt !== 16'd0) fail({w, " rej_cnt"}, rej_cnt, 0);
    endtask

    task automatic acquire(input int md, input bit mv, input int pd, input int xv, input int yv, input bit drop);
        bit seen;
        int tc, tu;
        seen = 1'b0;
        for (int n = 0; n < HC + 20; n++) begin
            if (mic_start === 1'b1) begin seen = 1'b1; break; end
            mic_done  = 1'($urandom_range(0, 1));
            mic_valid = 1'($urandom_range(0, 1));
            pos_done  = 1'($urandom_range(0, 1));
            tick();
        end
        mic_done = 1'b0;
        pos_done = 1'b0;
        vectors++; if (seen !== 1'b1) fail("start_seen", seen, 1);
        if (!seen) return;
        exp_start++;
        if (hold_at >= 0) begin
            vectors++; if ((cyc - hold_at) !== HC) fail("hold_gap", cyc - hold_at, HC);
        end
        if (md <= TMO) begin
            repeat (md) begin pos_done = 1'($urandom_range(0, 1)); tick(); end
            pos_done = 1'b0; mic_done = 1'b1; mic_valid = mv;
            tick();
            mic_done = 1'b0;
            if (!mv) begin
                exp_rej++;
                vectors++; if (pos_ena !== 1'b0) fail("rej_no_pos", pos_ena, 0);
                vectors++; if (rej_cnt !== 16'(exp_rej)) fail("rej_cnt", rej_cnt, exp_rej);
                vectors++; if (upd_cnt !== 16'(exp_upd)) fail("rej_upd_cnt", upd_cnt, exp_upd);
                vectors++; if (busy !== 1'b1) fail("rej_busy", busy, 1);
                hold_at = cyc;
                return;
            end
            vectors++; if (pos_ena !== 1'b1) fail("pos_ena", pos_ena, 1);
            vectors++; if (err_timeout !== err_exp) fail("err_after_mic", err_timeout, err_exp);
        end else begin
            repeat (TMO) begin pos_done = 1'($urandom_range(0, 1)); tick(); end
            pos_done = 1'b0;
            vectors++; if (err_timeout !== err_exp) fail("err_pre_mic_tmo", err_timeout, err_exp);
            tick();
            err_exp = 1'b1;
            vectors++; if (err_timeout !== 1'b1) fail("err_mic_tmo", err_timeout, 1);
            vectors++; if (pos_ena !== 1'b0) fail("mic_tmo_no_pos", pos_ena, 0);
            hold_at = cyc;
            return;
        end
        exp_pos++;
        tc = cyc;
        if (pd <= TMO) begin
            repeat (pd) begin
                mic_done = 1'($urandom_range(0, 1)); mic_valid = 1'($urandom_range(0, 1));
                x_in = CW'($urandom()); y_in = CW'($urandom());
                tick();
                if (drop) ena = 1'b0;
            end
            mic_done = 1'b0; x_in = xv[CW-1:0]; y_in = yv[CW-1:0]; pos_done = 1'b1;
            tick();
            pos_done = 1'b0; x_in = CW'($urandom()); y_in = CW'($urandom());
            tu = cyc;
            exp_upd++; exp_ovl++; err_exp = 1'b0;
            model_update(xv, yv);
            vectors++; if (ovl_ena !== OVL_EARLY) fail("ovl_at_update", ovl_ena, OVL_EARLY);
`ifdef ACQ_SMOOTH_EN
            tick();
            vectors++; if (ovl_ena !== 1'b1) fail("ovl_smooth", ovl_ena, 1);
`endif
            vectors++; if (pix_x !== CW'(pix_x_exp)) fail("pix_x", pix_x, pix_x_exp);
            vectors++; if (pix_y !== CW'(pix_y_exp)) fail("pix_y", pix_y, pix_y_exp);
            vectors++; if (upd_cnt !== 16'(exp_upd)) fail("upd_cnt", upd_cnt, exp_upd);
            vectors++; if (err_timeout !== 1'b0) fail("err_cleared", err_timeout, 0);
            hold_at = tu + 1;
        end else begin
            repeat (TMO) begin mic_done = 1'($urandom_range(0, 1)); tick(); end
            mic_done = 1'b0;
            vectors++; if (err_timeout !== err_exp) fail("err_pre_pos_tmo", err_timeout, err_exp);
            tick();
            err_exp = 1'b1;
            vectors++; if (err_timeout !== 1'b1) fail("err_pos_tmo", err_timeout, 1);
            vectors++; if (ovl_ena !== 1'b0) fail("pos_tmo_no_ovl", ovl_ena, 0);
            vectors++; if (upd_cnt !== 16'(exp_upd)) fail("pos_tmo_cnt", upd_cnt, exp_upd);
            hold_at = cyc;
        end
        if (tc < 0) hold_at = -1;
    endtask

    initial begin
        int md, pd, xv, yv, r;
        bit mv, seen;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_all_zero("idle");
        ena = 1'b1;

        acquire(100, 1'b1, 50, 120, 80, 1'b0);
        vectors++; if (pix_x !== CW'(120)) fail("nominal pix_x", pix_x, 120);
        vectors++; if (pix_y !== CW'(80)) fail("nominal pix_y", pix_y, 80);
        vectors++; if (upd_cnt !== 16'd1) fail("nominal upd_cnt", upd_cnt, 1);
        acquire(20, 1'b1, 30, -5, 300, 1'b0);
`ifndef ACQ_SMOOTH_EN
        vectors++; if (pix_x !== CW'(0)) fail("clamp neg x", pix_x, 0);
        vectors++; if (pix_y !== CW'(271)) fail("clamp big y", pix_y, 271);
`endif
        acquire(40, 1'b1, TMO, 480, 272, 1'b0);
`ifndef ACQ_SMOOTH_EN
        vectors++; if (pix_x !== CW'(479)) fail("clamp x=480", pix_x, 479);
`endif
        acquire(10, 1'b1, 1, 479, 0, 1'b0);
        acquire(30, 1'b0, 1, 0, 0, 1'b0);
        vectors++; if (rej_cnt !== 16'd1) fail("reject rej_cnt", rej_cnt, 1);
        acquire(TMO + 1, 1'b1, 1, 0, 0, 1'b0);
        vectors++; if (err_timeout !== 1'b1) fail("mic timeout flag", err_timeout, 1);
        acquire(5, 1'b1, TMO + 1, 0, 0, 1'b0);
        acquire(TMO, 1'b1, 9, 300, 200, 1'b0);
        vectors++; if (err_timeout !== 1'b0) fail("good update clears err", err_timeout, 0);

        acquire(12, 1'b1, 20, 50, 60, 1'b1);
        run_to(hold_at + HC - 1);
        vectors++; if (busy !== 1'b1) fail("drop busy in hold", busy, 1);
        tick();
        vectors++; if (busy !== 1'b0) fail("drop idle busy", busy, 0);
        vectors++; if (mic_start !== 1'b0) fail("drop no start", mic_start, 0);
        repeat (4) tick();
        vectors++; if (busy !== 1'b0) fail("drop stays idle", busy, 0);
        ena = 1'b1;
        hold_at = -1;

        for (int i = 0; i < 30; i++) begin
            md = $urandom_range(1, TMO + 10);
            pd = $urandom_range(1, TMO + 10);
            mv = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            xv = (r == 0) ? -(1 << 25) : (r == 1) ? (1 << 25) - 1 : int'($urandom_range(0, 700)) - 100;
            yv = (r == 2) ? -(1 << 25) : (r == 3) ? (1 << 25) - 1 : int'($urandom_range(0, 500)) - 100;
            acquire(md, mv, pd, xv, yv, 1'b0);
        end
        vectors++; if (n_start !== exp_start) fail("total mic_start pulses", n_start, exp_start);
        vectors++; if (n_pos !== exp_pos) fail("total pos_ena pulses", n_pos, exp_pos);
        vectors++; if (n_ovl !== exp_ovl) fail("total ovl_ena pulses", n_ovl, exp_ovl);
        vectors++; if (rej_cnt !== 16'(exp_rej)) fail("total rej_cnt", rej_cnt, exp_rej);

        seen = 1'b0;
        for (int n = 0; n < HC + 20; n++) begin
            if (mic_start === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        vectors++; if (seen !== 1'b1) fail("rst test start seen", seen, 1);
        repeat (10) tick();
        vectors++; if (busy !== 1'b1) fail("rst test in wait", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        ena = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        n_start = 0; n_pos = 0; n_ovl = 0;
        repeat (8) tick();
        vectors++; if (n_start !== 0) fail("post reset start pulses", n_start, 0);
        vectors++; if (n_pos !== 0) fail("post reset pos pulses", n_pos, 0);
        vectors++; if (n_ovl !== 0) fail("post reset ovl pulses", n_ovl, 0);
        vectors++; if (busy !== 1'b0) fail("post reset busy", busy, 0);
        exp_start = 0; exp_pos = 0; exp_ovl = 0; exp_upd = 0; exp_rej = 0;
        err_exp = 1'b0; pix_x_exp = 0; pix_y_exp = 0;
        hxq.delete(); hyq.delete();
        hold_at = -1;
        ena = 1'b1;

        for (int i = 0; i < 4; i++) begin
            acquire(15, 1'b1, 25, 100 * (i + 1), 10, 1'b0);
            vectors++; if (pix_x !== CW'(seq_exp[i])) fail("smooth sequence pix_x", pix_x, seq_exp[i]);
        end
        vectors++; if (n_start !== exp_start) fail("final mic_start pulses", n_start, exp_start);
        vectors++; if (n_ovl !== exp_ovl) fail("final ovl_ena pulses", n_ovl, exp_ovl);
        vectors++; if (upd_cnt !== 16'd4) fail("final upd_cnt", upd_cnt, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acq_scheduler.md
Name: acq_scheduler

Overview:
- Sequences one acoustic localisation cycle at a time: mic_subsys capture, then cal_position solve, then the video_subsys marker update.
- Replaces the free-running start (tied high) and the combinational subsys_done&valid hookup.
- Adds a rate limit, per-stage timeouts, coordinate clamping to the LCD area and status counters.
- Sits in top in the clk_12MHz domain, between the three subsystems.

Parameters:
- CW, 26, coordinate width (matches x_2d/y_2d).
- X_MAX, 480, LCD active width in pixels.
- Y_MAX, 272, LCD active height in pixels.
- TIMEOUT, 24'd6_000_000, maximum wait in WAIT_MIC or WAIT_POS (0.5 s at 12 MHz).
- HOLD_CYC, 20'd600_000, idle gap between acquisitions (50 ms).

Ports:
- clk  in  1  12 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global run enable (PAD_XC_EN)
- mic_done  in  1  mic_subsys subsys_done, one-cycle pulse
- mic_valid  in  1  mic_subsys valid, sampled with mic_done
- mic_start  out  1  one-cycle start pulse to mic_subsys
- pos_ena  out  1  one-cycle start pulse to cal_position
- pos_done  in  1  cal_position done pulse
- x_in  in  CW  cal_position x_2d, two's complement
- y_in  in  CW  cal_position y_2d, two's complement
- ovl_ena  out  1  one-cycle update pulse to video_subsys ena
- pix_x  out  CW  clamped x, registered
- pix_y  out  CW  clamped y, registered
- busy  out  1  high when state is not IDLE
- err_timeout  out  1  sticky timeout flag
- upd_cnt  out  16  count of successful updates, wraps at 0xFFFF->0
- rej_cnt  out  16  count of mic_valid=0 rejects, wraps

Behaviour:
- Reset values: every output 0; state=IDLE; timer=0.
- Interface as decided: one clock (clk); reset rst_n is asynchronous and active-low. All outputs are registered.
- FSM states: IDLE, START, WAIT_MIC, CALC, WAIT_POS, UPDATE, HOLD.
- IDLE: when ena=1, go to START on the next cycle.
- START: mic_start=1 for exactly this cycle; clear timer; go to WAIT_MIC.
- WAIT_MIC:
  - mic_done=1 and mic_valid=1 → CALC.
  - mic_done=1 and mic_valid=0 → rej_cnt+1, go to HOLD.
  - Otherwise, when timer reaches TIMEOUT-1 → err_timeout=1, go to HOLD.
- CALC: pos_ena=1 for this cycle; clear timer; go to WAIT_POS. Latency from mic_done to pos_ena is 1 cycle.
- WAIT_POS:
  - pos_done=1 → capture x_in/y_in, go to UPDATE.
  - Timer reaches TIMEOUT-1 → err_timeout=1, go to HOLD.
- UPDATE:
  - Clamp captured values: negative → 0; ≥X_MAX → X_MAX-1 (y uses Y_MAX-1). The comparison is signed on all CW bits.
  - Load pix_x/pix_y; ovl_ena=1 for this cycle; upd_cnt+1; clear err_timeout; go to HOLD.
  - Latency from pos_done to ovl_ena is 1 cycle. pix_x/pix_y are valid in the same cycle as ovl_ena and hold until the next UPDATE.
- HOLD: count HOLD_CYC cycles, then go to START if ena=1, else IDLE.
- Simultaneous events:
  - mic_done and timer expiry in the same cycle: mic_done wins.
  - pos_done and expiry in the same cycle: pos_done wins.
- Stray pulses: mic_done or pos_done outside its own wait state is ignored.
- ena=0 mid-cycle: the current acquisition completes; ena is sampled only in IDLE and at HOLD exit.
- Reset mid-operation: immediate return to IDLE; no pulse is emitted.
- Timer: 24 bits, saturating; it never wraps inside a wait state.

Optional Feature:
- Macro: ACQ_SMOOTH_EN.
- Defined:
  - A 4-entry history of clamped coordinates.
  - pix_x/pix_y = (sum of the last 4 entries) >> 2, truncated, using a CW+2-bit accumulator.
  - The history is filled with the first sample after reset, so the first output equals that sample.
  - ovl_ena moves to one cycle after UPDATE (latency 2 from pos_done).
  - The history clears on reset only.
- Undefined: raw clamped values are output, with ovl_ena at latency 1. The history logic is absent.

Test Plan:
- Nominal run: ena=1, mic_done+mic_valid 100 cycles after mic_start, pos_done 50 cycles later with x_in=120, y_in=80. Required: pos_ena 1 cycle after mic_done; ovl_ena 1 cycle after pos_done; pix_x=120, pix_y=80; upd_cnt=1; next mic_start exactly HOLD_CYC cycles after HOLD entry.
- Clamping: x_in=-5, y_in=300 → pix_x=0, pix_y=271. x_in=480 → pix_x=479.
- Reject: mic_done with mic_valid=0 → no pos_ena; rej_cnt=1; upd_cnt unchanged; HOLD entered.
- Timeout (TIMEOUT overridden to 100): no mic_done → err_timeout=1 at cycle 100 after START; later a good update clears it. Separately, mic_done at the expiry cycle → CALC with err_timeout=0.
- Control: ena dropped during WAIT_POS → update still completes, then IDLE with busy=0. rst_n asserted in WAIT_MIC → all outputs 0 asynchronously and no stray pulses after release.
- ACQ_SMOOTH_EN: x sequence 100, 200, 300, 400 → pix_x 100, 125, 175, 250.
